// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types for the regfile_mp multi-port register file.
//  ld_state_e : load scoreboard FSM states
//  wr_src_e   : which core write source won arbitration
//  rd_port_t  : per-read-port forwarding/busy status
package regfile_pkg;
   typedef enum logic {LD_IDLE, LD_PEND} ld_state_e;
   typedef enum logic [1:0] {SRC_NONE, SRC_IMM, SRC_MOV, SRC_WR} wr_src_e;
   typedef struct packed {
      logic hit_core;
      logic hit_ld;
      logic busy;
   } rd_port_t;
endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: resolves load-immediate / move / core write into one write (Imm > Mov > Wr).
//  i_imm_en, i_imm                      : load-immediate into IMM_REG
//  i_mov_en, i_mov_src, i_mov_dst       : register move request
//  i_mov_data                           : current (pre-edge) contents of the move source
//  i_wr_en, i_wr_addr, i_wr_data        : core write port
//  o_en, o_addr, o_data                 : single resolved write
module regfile_wr_arb
   import regfile_pkg::*;
#(
   parameter int W       = 8,
   parameter int A       = 4,
   parameter int IMM_REG = 3
) (
   input  logic         i_imm_en,
   input  logic [W-1:0] i_imm,
   input  logic         i_mov_en,
   input  logic [A-1:0] i_mov_src,
   input  logic [A-1:0] i_mov_dst,
   input  logic [W-1:0] i_mov_data,
   input  logic         i_wr_en,
   input  logic [A-1:0] i_wr_addr,
   input  logic [W-1:0] i_wr_data,
   output logic         o_en,
   output logic [A-1:0] o_addr,
   output logic [W-1:0] o_data
);
   wr_src_e w_src;
   // A move onto itself still wins priority but commits nothing.
   always_comb begin
      w_src  = i_imm_en ? SRC_IMM : i_mov_en ? SRC_MOV : i_wr_en ? SRC_WR : SRC_NONE;
      o_en   = (w_src == SRC_MOV) ? (i_mov_src != i_mov_dst) : (w_src != SRC_NONE);
      o_addr = (w_src == SRC_IMM) ? A'(IMM_REG) : (w_src == SRC_MOV) ? i_mov_dst : i_wr_addr;
      o_data = (w_src == SRC_IMM) ? i_imm : (w_src == SRC_MOV) ? i_mov_data : i_wr_data;
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a one-outstanding-load scoreboard.
//  i_clk, i_rst_n                        : clock, async active-low reset
//  i_wr_en/i_wr_addr/i_wr_data           : core write
//  i_imm_en/i_imm                        : load-immediate into IMM_REG
//  i_mov_en/i_mov_src/i_mov_dst          : register move
//  i_ld_issue/i_ld_addr                  : load issue
//  i_ld_done/i_ld_data                   : memory return
//  i_rd_addr / o_rd_data / o_rd_busy     : NRD combinational read ports
//  o_ld_pending, o_ld_reject             : load outstanding, registered issue-refused pulse
//  Macro REGFILE_BYPASS_EN: forward same-cycle commits to the read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int W       = 8,
   parameter int A       = 4,
   parameter int NRD     = 3,
   parameter int ZERO_R0 = 0,
   parameter int IMM_REG = 3
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_wr_en,
   input  logic [A-1:0]            i_wr_addr,
   input  logic [W-1:0]            i_wr_data,
   input  logic                    i_imm_en,
   input  logic [W-1:0]            i_imm,
   input  logic                    i_mov_en,
   input  logic [A-1:0]            i_mov_src,
   input  logic [A-1:0]            i_mov_dst,
   input  logic                    i_ld_issue,
   input  logic [A-1:0]            i_ld_addr,
   input  logic                    i_ld_done,
   input  logic [W-1:0]            i_ld_data,
   input  logic [NRD-1:0][A-1:0]   i_rd_addr,
   output logic [NRD-1:0][W-1:0]   o_rd_data,
   output logic [NRD-1:0]          o_rd_busy,
   output logic                    o_ld_pending,
   output logic                    o_ld_reject
);
   localparam int NR = 2**A;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic [W-1:0] r_regs [NR];
   logic [NR-1:0] r_busy;
   ld_state_e r_state;
   logic [A-1:0] r_pend_addr;
   logic r_ld_reject;
   ld_state_e w_state_next;
   logic [NR-1:0] w_busy_next;
   logic w_arb_en, w_core_en, w_ld_done, w_ld_wr, w_waw, w_issue;
   logic [A-1:0] w_arb_addr;
   logic [W-1:0] w_arb_data, w_mov_data;
   regfile_wr_arb #(.W(W), .A(A), .IMM_REG(IMM_REG)) u_arb (
      .i_imm_en   (i_imm_en),
      .i_imm      (i_imm),
      .i_mov_en   (i_mov_en),
      .i_mov_src  (i_mov_src),
      .i_mov_dst  (i_mov_dst),
      .i_mov_data (w_mov_data),
      .i_wr_en    (i_wr_en),
      .i_wr_addr  (i_wr_addr),
      .i_wr_data  (i_wr_data),
      .o_en       (w_arb_en),
      .o_addr     (w_arb_addr),
      .o_data     (w_arb_data)
   );
   // Busy[PendAddr] doubles as "load still live": a WAW write clears it, so the
   // eventual LdDone is consumed without writing. With ZERO_R0 it is never set for r0.
   always_comb begin
      w_mov_data = r_regs[i_mov_src];
      w_core_en  = w_arb_en && !(ZERO_R0 != 0 && w_arb_addr == '0);
      w_issue    = (r_state == LD_IDLE) && i_ld_issue;
      w_ld_done  = (r_state == LD_PEND) && i_ld_done;
      w_waw      = (r_state == LD_PEND) && w_core_en && (w_arb_addr == r_pend_addr);
      w_ld_wr    = w_ld_done && r_busy[r_pend_addr] && !w_waw;
   end
   always_comb begin
      w_state_next = (r_state == LD_IDLE) ? (i_ld_issue ? LD_PEND : LD_IDLE)
                                          : (i_ld_done ? LD_IDLE : LD_PEND);
      w_busy_next = r_busy;
      if (w_ld_done || w_waw) w_busy_next[r_pend_addr] = 1'b0;
      if (w_issue) w_busy_next[i_ld_addr] = !(ZERO_R0 != 0 && i_ld_addr == '0);
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= LD_IDLE;
         r_pend_addr <= '0;
         r_busy      <= '0;
         r_ld_reject <= 1'b0;
         r_regs      <= '{default: '0};
      end else begin
         r_state     <= w_state_next;
         r_busy      <= w_busy_next;
         r_ld_reject <= (r_state == LD_PEND) && i_ld_issue;
         if (w_issue) r_pend_addr <= i_ld_addr;
         if (w_core_en) r_regs[w_arb_addr] <= w_arb_data;
         if (w_ld_wr) r_regs[r_pend_addr] <= i_ld_data;
      end
   end
   genvar g;
   for (g = 0; g < NRD; g++) begin : g_rd
      rd_port_t w_port;
      always_comb begin
         w_port.hit_core = BYP && w_core_en && (w_arb_addr == i_rd_addr[g]);
         w_port.hit_ld   = BYP && w_ld_wr && (r_pend_addr == i_rd_addr[g]);
         w_port.busy     = r_busy[i_rd_addr[g]] && !(BYP && w_ld_done && (r_pend_addr == i_rd_addr[g]));
         o_rd_data[g]    = (ZERO_R0 != 0 && i_rd_addr[g] == '0) ? '0
                         : w_port.hit_core ? w_arb_data
                         : w_port.hit_ld ? i_ld_data
                         : r_regs[i_rd_addr[g]];
         o_rd_busy[g]    = w_port.busy;
      end
   end
   assign o_ld_pending = (r_state == LD_PEND);
   assign o_ld_reject  = r_ld_reject;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (ZERO_R0=0 and ZERO_R0=1 instances, shared stimulus).
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   typedef struct packed {
      logic [1:0][2:0][7:0] d;
      logic [1:0][2:0]      b;
      logic [1:0]           p;
      logic [1:0]           r;
   } exp_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n, wr_en, imm_en, mov_en, ld_issue, ld_done;
   logic [3:0] wr_addr, mov_src, mov_dst, ld_addr;
   logic [7:0] wr_data, imm, ld_data;
   logic [2:0][3:0] rd_addr;
   logic [1:0][2:0][7:0] rd_data;
   logic [1:0][2:0] rd_busy;
   logic [1:0] pend, rej;
   int checks = 0, failures = 0;
   exp_t q[$];
   logic [7:0] m_regs [2][16];
   bit m_pend [2];
   bit m_live [2];
   bit m_rej [2];
   logic [3:0] m_paddr [2];

   regfile_mp #(.ZERO_R0(0)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_imm_en(imm_en), .i_imm(imm), .i_mov_en(mov_en), .i_mov_src(mov_src), .i_mov_dst(mov_dst),
      .i_ld_issue(ld_issue), .i_ld_addr(ld_addr), .i_ld_done(ld_done), .i_ld_data(ld_data),
      .i_rd_addr(rd_addr), .o_rd_data(rd_data[0]), .o_rd_busy(rd_busy[0]),
      .o_ld_pending(pend[0]), .o_ld_reject(rej[0]));
   regfile_mp #(.ZERO_R0(1)) u_dut_z (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_imm_en(imm_en), .i_imm(imm), .i_mov_en(mov_en), .i_mov_src(mov_src), .i_mov_dst(mov_dst),
      .i_ld_issue(ld_issue), .i_ld_addr(ld_addr), .i_ld_done(ld_done), .i_ld_data(ld_data),
      .i_rd_addr(rd_addr), .o_rd_data(rd_data[1]), .o_rd_busy(rd_busy[1]),
      .o_ld_pending(pend[1]), .o_ld_reject(rej[1]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Winning write for instance k: {en, addr, data}.
   function automatic logic [12:0] winner(int k);
      logic en;
      logic [3:0] a;
      logic [7:0] d;
      if (imm_en) {en, a, d} = {1'b1, 4'd3, imm};
      else if (mov_en) {en, a, d} = {mov_src != mov_dst, mov_dst, m_regs[k][mov_src]};
      else if (wr_en) {en, a, d} = {1'b1, wr_addr, wr_data};
      else {en, a, d} = '0;
      if (k == 1 && a == 4'd0) en = 1'b0;
      return {en, a, d};
   endfunction

   function automatic bit ld_writes(int k, logic [12:0] w);
      return m_pend[k] && ld_done && m_live[k] && !(w[12] && w[11:8] == m_paddr[k]);
   endfunction

   function automatic exp_t expect_now();
      exp_t e;
      e = '0;
      for (int k = 0; k < 2; k++) begin
         logic [12:0] w;
         bit lw;
         w = winner(k);
         lw = ld_writes(k, w);
         for (int i = 0; i < 3; i++) begin
            logic [3:0] ra;
            logic [7:0] d;
            ra = rd_addr[i];
            d = m_regs[k][ra];
            if (BYP && w[12] && w[11:8] == ra) d = w[7:0];
            else if (BYP && lw && m_paddr[k] == ra) d = ld_data;
            if (k == 1 && ra == 4'd0) d = 8'd0;
            e.d[k][i] = d;
            e.b[k][i] = m_pend[k] && m_live[k] && m_paddr[k] == ra && !(BYP && ld_done);
         end
         e.p[k] = m_pend[k];
         e.r[k] = m_rej[k];
      end
      return e;
   endfunction

   task automatic step();
      for (int k = 0; k < 2; k++) begin
         logic [12:0] w;
         bit lw, rj;
         w = winner(k);
         lw = ld_writes(k, w);
         rj = m_pend[k] && ld_issue;
         if (w[12]) m_regs[k][w[11:8]] = w[7:0];
         if (lw) m_regs[k][m_paddr[k]] = ld_data;
         if (m_pend[k] && ld_done) m_pend[k] = 0;
         else if (m_pend[k] && w[12] && w[11:8] == m_paddr[k]) m_live[k] = 0;
         else if (!m_pend[k] && ld_issue) begin
            m_pend[k] = 1;
            m_paddr[k] = ld_addr;
            m_live[k] = !(k == 1 && ld_addr == 4'd0);
         end
         m_rej[k] = rj;
      end
   endtask

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 16; r++) m_regs[k][r] = 8'd0;
         m_pend[k] = 0; m_live[k] = 0; m_rej[k] = 0; m_paddr[k] = 4'd0;
      end
   endtask

   task automatic idle();
      {wr_en, imm_en, mov_en, ld_issue, ld_done} = '0;
      {wr_addr, mov_src, mov_dst, ld_addr} = '0;
      {wr_data, imm, ld_data} = '0;
   endtask

   task automatic cyc();
      q.push_back(expect_now());
      @(posedge clk);
      #1;
      if (rst_n) step();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_rd_data", 64'(rd_data), 64'(e.d));
            chk("sb_rd_busy", 64'(rd_busy), 64'(e.b));
            chk("sb_pending", 64'(pend), 64'(e.p));
            chk("sb_reject", 64'(rej), 64'(e.r));
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : driver
      rst_n = 1'b0;
      idle();
      rd_addr = '0;
      mreset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc();
      // Imm beats a same-cycle core write to r3
      imm_en = 1; imm = 8'hA5; wr_en = 1; wr_addr = 4'd3; wr_data = 8'h11;
      cyc(); idle(); rd_addr[0] = 4'd3; #1;
      chk("imm_pri", rd_data[0][0], 8'hA5);
      chk("imm_pri_z", rd_data[1][0], 8'hA5);
      // load to r5, completes two cycles after issue
      ld_issue = 1; ld_addr = 4'd5;
      cyc(); idle(); rd_addr[1] = 4'd5; #1;
      chk("ld_busy", rd_busy[0][1], 1'b1);
      chk("ld_pend", pend[0], 1'b1);
      cyc();
      ld_done = 1; ld_data = 8'h3C;
      cyc(); idle(); #1;
      chk("ld_data", rd_data[0][1], 8'h3C);
      chk("ld_unbusy", rd_busy[0][1], 1'b0);
      chk("ld_idle", pend[0], 1'b0);
      // WAW: core write cancels the pending load
      ld_issue = 1; ld_addr = 4'd5;
      cyc(); idle(); wr_en = 1; wr_addr = 4'd5; wr_data = 8'h77;
      cyc(); idle(); ld_done = 1; ld_data = 8'h99;
      cyc(); idle(); #1;
      chk("waw_keep", rd_data[0][1], 8'h77);
      chk("waw_idle", pend[0], 1'b0);
      // issue while pending is rejected for one cycle
      ld_issue = 1; ld_addr = 4'd6;
      cyc(); ld_addr = 4'd7;
      cyc(); idle(); rd_addr[2] = 4'd6; rd_addr[0] = 4'd7; #1;
      chk("rej_pulse", rej[0], 1'b1);
      chk("rej_keep6", rd_busy[0][2], 1'b1);
      chk("rej_not7", rd_busy[0][0], 1'b0);
      cyc(); #1;
      chk("rej_once", rej[0], 1'b0);
      ld_done = 1; ld_data = 8'h5A;
      cyc(); idle(); #1;
      chk("rej_r6", rd_data[0][2], 8'h5A);
      chk("rej_r7", rd_data[0][0], 8'h00);
      // same-cycle read of a write: forwarded only with bypass
      wr_en = 1; wr_addr = 4'd2; wr_data = 8'h10;
      cyc(); wr_data = 8'h42; rd_addr[0] = 4'd2; #1;
      chk("bypass", rd_data[0][0], BYP ? 8'h42 : 8'h10);
      cyc(); idle(); #1;
      chk("wr_r2", rd_data[0][0], 8'h42);
      // r0 hardwired to zero only in the ZERO_R0 instance
      wr_en = 1; wr_addr = 4'd0; wr_data = 8'hFF; rd_addr[0] = 4'd0;
      cyc(); idle(); #1;
      chk("zero_r0", rd_data[1][0], 8'h00);
      chk("r0_norm", rd_data[0][0], 8'hFF);
      // randomized traffic with an asynchronous reset in the middle
      for (int n = 0; n < 1200; n++) begin
         if (n == 600) begin
            idle();
            #2;
            rst_n = 1'b0;
            mreset();
            cyc();
            rst_n = 1'b1;
         end
         imm_en   = ($urandom_range(0, 9) == 0);
         imm      = 8'($urandom);
         mov_en   = ($urandom_range(0, 6) == 0);
         mov_src  = 4'($urandom);
         mov_dst  = 4'($urandom);
         wr_en    = ($urandom_range(0, 4) < 2);
         wr_addr  = ($urandom_range(0, 3) == 0) ? m_paddr[0] : 4'($urandom);
         wr_data  = 8'($urandom);
         ld_issue = ($urandom_range(0, 3) == 0);
         ld_addr  = 4'($urandom);
         ld_done  = ($urandom_range(0, 2) == 0);
         ld_data  = 8'($urandom);
         for (int i = 0; i < 3; i++) rd_addr[i] = ($urandom_range(0, 3) == 0) ? m_paddr[0] : 4'($urandom);
         cyc();
      end
      idle();
      @(negedge clk);
      #1;
      chk("sb_drain", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
